// File: rtl/sensor_uart_rx.sv
// 8N1 UART receiver feeding the sensor PIO input port.
// data_out changes only on a complete frame with a good stop bit.
module sensor_uart_rx #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rxd,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_err,
    output logic       rx_busy
);

    // state    | meaning
    // ST_IDLE  | line idle, waiting for a falling edge on rxs
    // ST_START | counting to mid start bit, rejecting glitches
    // ST_DATA  | sampling 8 data bits mid-bit, LSB first
    // ST_STOP  | sampling the stop bit
    // ST_BREAK | bad stop bit, waiting for the line to return high
    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP, ST_BREAK} state_t;

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [SYNC_STAGES:0]   fill_q, fill_d;
    logic                   prev_q, prev_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [2:0]             bit_q, bit_d;
    logic [7:0]             shreg_q, shreg_d;
    logic [7:0]             data_out_q, data_out_d;
    logic                   valid_q, valid_d;
    logic                   ferr_q, ferr_d;
    logic                   busy_q, busy_d;

    logic rxs;
    logic armed;
    logic tick;

    assign rxs = sync_q[SYNC_STAGES-1];
    // The preset synchroniser would otherwise fake a falling edge when the
    // line is already low at reset release; only trust edges once real
    // samples have reached prev_q.
    assign armed = fill_q[SYNC_STAGES];
    assign tick  = (state_q == ST_START) ? (cnt_q == HALF_LAST) : (cnt_q == BIT_LAST);

    assign sync_d = {sync_q[SYNC_STAGES-2:0], rxd};
    assign fill_d = {fill_q[SYNC_STAGES-1:0], 1'b1};
    assign prev_d = rxs;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            sync_q     <= '1;
            fill_q     <= '0;
            prev_q     <= 1'b1;
            cnt_q      <= '0;
            bit_q      <= '0;
            shreg_q    <= '0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_q     <= sync_d;
            fill_q     <= fill_d;
            prev_q     <= prev_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shreg_q    <= shreg_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
            busy_q     <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (armed && prev_q && !rxs) state_d = ST_START;
            ST_START: if (tick) state_d = rxs ? ST_IDLE : ST_DATA;
            ST_DATA:  if (tick && bit_q == 3'd7) state_d = ST_STOP;
            ST_STOP:  if (tick) state_d = rxs ? ST_IDLE : ST_BREAK;
            ST_BREAK: if (rxs) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        shreg_d    = shreg_q;
        data_out_d = data_out_q;
        valid_d    = 1'b0;
        ferr_d     = ferr_q;
        case (state_q)
            ST_START, ST_DATA, ST_STOP: begin
                if (tick) cnt_d = '0;
                else      cnt_d = cnt_q + CW'(1);
                if (tick && state_q == ST_START) bit_d = '0;
                if (tick && state_q == ST_DATA) begin
                    shreg_d = {rxs, shreg_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                end
                if (tick && state_q == ST_STOP) begin
                    if (rxs) begin
                        data_out_d = shreg_q;
                        valid_d    = 1'b1;
                        ferr_d     = 1'b0;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
            end
            default: begin
                cnt_d = '0;
                bit_d = '0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    assign data_out   = data_out_q;
    assign data_valid = valid_q;
    assign frame_err  = ferr_q;
    assign rx_busy    = busy_q;

endmodule

// File: tb/tb_sensor_uart_rx.sv
// Self-checking bench for sensor_uart_rx: frame vector table, scoreboard on
// data_valid, and hand sequences for glitch, reset and break cases.
module tb_sensor_uart_rx;

    localparam int CPB  = 8;
    localparam int SYNC = 2;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       rxd = 1'b1;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       rx_busy;

    int errors = 0;
    int checks = 0;
    int pulses = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic [7:0] exp_data;
        logic       exp_ferr;
        int         exp_pulses;
    } vec_t;
    vec_t vecs[5];

    sensor_uart_rx #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .reset_n(reset_n), .rxd(rxd),
        .data_out(data_out), .data_valid(data_valid),
        .frame_err(frame_err), .rx_busy(rx_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input int idle_bits);
        if (stop) exp_q.push_back(d);
        rxd = 1'b0;
        wait_clks(CPB);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            wait_clks(CPB);
        end
        rxd = stop;
        wait_clks(CPB);
        rxd = 1'b1;
        wait_clks(idle_bits * CPB);
    endtask

    task automatic monitor();
        logic last_v = 1'b0;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (data_valid) begin
                pulses++;
                if (last_v) check("valid_width", 2, 1);
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", int'(data_out), -1);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_data", int'(data_out), int'(e));
                    check("sb_ferr", int'(frame_err), 0);
                end
            end
            last_v = data_valid;
        end
    endtask

    initial begin
        int p0;
        int busy_cnt;
        int n;

        vecs[0] = '{8'hA5, 1'b1, 8'hA5, 1'b0, 1};
        vecs[1] = '{8'h55, 1'b0, 8'hA5, 1'b1, 0};
        vecs[2] = '{8'h0F, 1'b1, 8'h0F, 1'b0, 1};
        vecs[3] = '{8'h00, 1'b1, 8'h00, 1'b0, 1};
        vecs[4] = '{8'hFF, 1'b1, 8'hFF, 1'b0, 1};

        fork
            monitor();
        join_none

        // Reset values
        wait_clks(3);
        check("rst_data", int'(data_out), 0);
        check("rst_valid", int'(data_valid), 0);
        check("rst_ferr", int'(frame_err), 0);
        check("rst_busy", int'(rx_busy), 0);
        reset_n = 1'b1;
        wait_clks(6);

        // Table-driven frames
        for (int i = 0; i < 5; i++) begin
            p0 = pulses;
            send_frame(vecs[i].data, vecs[i].stop, 2);
            check($sformatf("vec%0d_data", i), int'(data_out), int'(vecs[i].exp_data));
            check($sformatf("vec%0d_ferr", i), int'(frame_err), int'(vecs[i].exp_ferr));
            check($sformatf("vec%0d_busy", i), int'(rx_busy), 0);
            check($sformatf("vec%0d_pulses", i), pulses - p0, vecs[i].exp_pulses);
        end

        // Back-to-back frames, no idle between stop and next start
        p0 = pulses;
        send_frame(8'h3C, 1'b1, 0);
        send_frame(8'hC3, 1'b1, 2);
        check("b2b_pulses", pulses - p0, 2);
        check("b2b_data", int'(data_out), 8'hC3);

        // Two-cycle low glitch on idle line
        p0 = pulses;
        busy_cnt = 0;
        rxd = 1'b0;
        wait_clks(2);
        rxd = 1'b1;
        for (int i = 0; i < 20; i++) begin
            wait_clks(1);
            if (rx_busy) busy_cnt++;
        end
        check_range("glitch_busy", busy_cnt, 1, 6);
        check("glitch_pulses", pulses - p0, 0);
        check("glitch_data", int'(data_out), 8'hC3);
        check("glitch_ferr", int'(frame_err), 0);

        // Reset during bit 4 of 0xFF, release with line low
        rxd = 1'b0;
        wait_clks(CPB);
        for (int i = 0; i < 4; i++) begin
            rxd = 1'b1;
            wait_clks(CPB);
        end
        wait_clks(CPB / 2);
        rxd = 1'b0;
        reset_n = 1'b0;
        wait_clks(2);
        check("midrst_data", int'(data_out), 0);
        check("midrst_valid", int'(data_valid), 0);
        check("midrst_ferr", int'(frame_err), 0);
        check("midrst_busy", int'(rx_busy), 0);
        p0 = pulses;
        reset_n = 1'b1;
        busy_cnt = 0;
        for (int i = 0; i < 20 * CPB; i++) begin
            wait_clks(1);
            if (rx_busy) busy_cnt++;
        end
        check("low_after_rst_busy", busy_cnt, 0);
        rxd = 1'b1;
        wait_clks(2 * CPB);
        send_frame(8'h81, 1'b1, 2);
        check("post_rst_pulses", pulses - p0, 1);
        check("post_rst_data", int'(data_out), 8'h81);
        check("post_rst_ferr", int'(frame_err), 0);

        // Line held low for 40 bit times
        p0 = pulses;
        rxd = 1'b0;
        wait_clks(40 * CPB);
        check("brk_ferr", int'(frame_err), 1);
        check("brk_busy", int'(rx_busy), 1);
        check("brk_pulses", pulses - p0, 0);
        check("brk_data", int'(data_out), 8'h81);
        rxd = 1'b1;
        n = 0;
        for (int i = 1; i <= 10; i++) begin
            wait_clks(1);
            if (!rx_busy) begin
                n = i;
                break;
            end
        end
        check_range("brk_exit_cycles", n, 1, SYNC + 1);
        check("brk_ferr_sticky", int'(frame_err), 1);

        wait_clks(4);
        check("sb_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sensor_uart_rx.md
Name: sensor_uart_rx

Overview:
- Serial receiver for the remote-sensing front end. Deserialises 8N1 UART bytes from the external sensor line.
- Presents the last good byte on a stable 8-bit bus that drives the NIOS PIO input port (in_port), plus status strobes.
- Sits directly upstream of the input PIO. The PIO samples data_out every clock, so data_out must only change on a complete, valid frame.

Parameters:
- CLKS_PER_BIT, 5208, clk cycles per UART bit (50 MHz / 9600 baud); legal range 4..65535.
- SYNC_STAGES, 2, flip-flops in the rxd synchroniser; legal range 2..3.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- rxd  in  1  asynchronous serial line; idles high.
- data_out  out  8  last correctly framed byte; connects to PIO in_port.
- data_valid  out  1  one-cycle pulse when data_out is updated.
- frame_err  out  1  sticky; set on a bad stop bit, cleared by the next good byte.
- rx_busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (asynchronous, reset_n low):
  - data_out = 8'h00, data_valid = 0, frame_err = 0, rx_busy = 0.
  - Synchroniser flops preset to 1; FSM = IDLE; bit counter = 0; clock-divider counter = 0.
- Synchroniser: rxd passes through SYNC_STAGES flops to give rxs. All decisions use rxs only.
- Divider counter: counts 0..N-1, then restarts. The "tick" is the cycle the count reaches N-1.
- FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE:
    - Stay while rxs = 1.
    - On rxs = 0: go to START, clear the divider.
  - START (half-bit check):
    - Tick at count = CLKS_PER_BIT/2 - 1 (integer division).
    - If rxs = 0 at the tick: go to DATA, clear divider and bit counter.
    - If rxs = 1 at the tick: glitch; return to IDLE with no output change.
  - DATA:
    - Tick every CLKS_PER_BIT cycles; each tick samples mid-bit.
    - Shift register loads LSB first: shreg <= {rxs, shreg[7:1]}; bit counter increments.
    - After the 8th sample (bit counter = 7 at the tick), go to STOP.
  - STOP:
    - Tick after CLKS_PER_BIT cycles, sampling mid-stop-bit.
    - rxs = 1: data_out <= shreg, data_valid <= 1 for exactly the next cycle, frame_err <= 0, go to IDLE.
    - rxs = 0: frame_err <= 1, data_out unchanged, no data_valid, go to BREAK.
  - BREAK:
    - Wait for rxs = 1, then go to IDLE.
    - Holding rxd low indefinitely never produces data_valid.
- Latency: data_valid and the new data_out appear 1 clk after the mid-stop-bit sample edge, plus SYNC_STAGES clocks of synchroniser delay relative to rxd.
- data_out and frame_err are registered outputs and stay constant between updates.
- rx_busy is a registered decode of state != IDLE.
- Back-to-back frames: a start edge is accepted in IDLE the cycle after STOP completes. No dead time is required beyond the half stop bit.
- Reset asserted mid-frame: everything returns to reset values immediately. The partial byte is discarded. After release, a line still low stays in IDLE until a new falling transition appears on rxs.
  - Implement this with a registered previous-rxs flag, reset to 1. IDLE requires prev = 1 and rxs = 0 to enter START.
- Divider counter width: $clog2(CLKS_PER_BIT); no wrap beyond CLKS_PER_BIT-1.

Test Plan (CLKS_PER_BIT = 8, SYNC_STAGES = 2):
1. Send 8'hA5 with a good stop bit -> exactly one data_valid pulse; data_out = 8'hA5 from that cycle; frame_err = 0; rx_busy low afterwards.
2. Send 8'h3C then 8'hC3 back-to-back, with no idle between the stop bit and the next start bit -> two pulses, data_out 8'h3C then 8'hC3; no missed or extra pulses.
3. Send 8'h55 with a stop bit of 0, then rxd high -> frame_err = 1; data_out keeps the previous value; no pulse; FSM passes through BREAK. A following good 8'h0F -> data_out = 8'h0F, frame_err = 0.
4. Low glitch of 2 clk on an idle line -> START aborts at the half-bit check; no pulse; data_out and frame_err unchanged; rx_busy high for at most 4 + 2 cycles.
5. Assert reset_n low during bit 4 of 8'hFF, release with rxd low, then raise rxd and send 8'h81 -> outputs go to 0 during reset; no byte from the aborted frame; only 8'h81 is delivered.
6. Hold rxd low for 40 bit times, then high -> one frame_err set; zero data_valid pulses; FSM returns to IDLE within SYNC_STAGES + 1 cycles of rxd rising.
